// File: rtl/sirv_bootrom_pkg.sv
// rtl/sirv_bootrom_pkg.sv - shared instruction encodings for the boot ROM images
//
// Holds the RISC-V instruction words used to build both boot images and a
// helper that forms "lui t0, addr[31:12]".
package sirv_bootrom_pkg;

    localparam logic [31:0] OPC_LUI_T0 = 32'h0000_02b7;
    localparam logic [31:0] INSN_JR_T0 = 32'h0002_8067;
    localparam logic [31:0] INSN_J_P10 = 32'h0100_006f;
    localparam logic [31:0] INSN_NOP   = 32'h0000_0013;

    // lui t0 with the upper 20 bits of addr; low 12 bits of addr are dropped.
    function automatic logic [31:0] mk_lui_t0(input logic [31:0] addr);
        return OPC_LUI_T0 | {addr[31:12], 12'h000};
    endfunction

endpackage

// File: rtl/sirv_bootrom_img.sv
// rtl/sirv_bootrom_img.sv - combinational boot image generator
//
// Ports:
//   sel  - image select: 0 = direct jump, 1 = XIP stub
//   idx  - word index into the ROM
//   word - image word at idx (zero beyond the populated words or DP)
module sirv_bootrom_img
    import sirv_bootrom_pkg::*;
#(
    parameter int          IW       = 10,
    parameter int          DP       = 1024,
    parameter logic [31:0] TGT_ADDR = 32'h8000_0000,
    parameter logic [31:0] CFG_WORD = 32'h0000_6661
) (
    input  logic          sel,
    input  logic [IW-1:0] idx,
    output logic [31:0]   word
);

    localparam logic [31:0] LUI_TGT = mk_lui_t0(TGT_ADDR);

    always_comb begin
        word = '0;
        if (32'(idx) < 32'(DP)) begin
            if (!sel) begin
                case (idx)
                    IW'(0):  word = LUI_TGT;
                    IW'(1):  word = INSN_JR_T0;
                    default: word = '0;
                endcase
            end else begin
                // j +0x10 skips the two nops and the config word to land on word4
                case (idx)
                    IW'(0):  word = INSN_J_P10;
                    IW'(1):  word = INSN_NOP;
                    IW'(2):  word = INSN_NOP;
                    IW'(3):  word = CFG_WORD;
                    IW'(4):  word = LUI_TGT;
                    IW'(5):  word = INSN_JR_T0;
                    default: word = '0;
                endcase
            end
        end
    end

endmodule

// File: rtl/sirv_bootrom_icb.sv
// rtl/sirv_bootrom_icb.sv - boot ROM with ICB slave port and strap-selected image
//
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   boot_sel              - image strap, sampled on the first edge after reset
//   icb_cmd_*             - command channel (valid/ready/addr/read/wdata/wmask)
//   icb_rsp_*             - response channel (valid/ready/rdata/err)
// Reads return the image word one cycle after accept; writes and reads past
// DP return err=1 with rdata=0.
module sirv_bootrom_icb
    import sirv_bootrom_pkg::*;
#(
    parameter int          AW       = 12,
    parameter int          DW       = 32,
    parameter int          DP       = 1024,
    parameter logic [31:0] TGT_ADDR = 32'h8000_0000,
    parameter logic [31:0] CFG_WORD = 32'h0000_6661
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            boot_sel,
    input  logic            icb_cmd_valid,
    output logic            icb_cmd_ready,
    input  logic [AW-1:0]   icb_cmd_addr,
    input  logic            icb_cmd_read,
    input  logic [DW-1:0]   icb_cmd_wdata,
    input  logic [DW/8-1:0] icb_cmd_wmask,
    output logic            icb_rsp_valid,
    input  logic            icb_rsp_ready,
    output logic [DW-1:0]   icb_rsp_rdata,
    output logic            icb_rsp_err
);

    localparam int IW = AW - 2;

    if (DW != 32) begin : g_dw_chk
        $fatal(1, "sirv_bootrom_icb: DW must be 32");
    end
    if (DP < 8 || DP > (1 << IW)) begin : g_dp_chk
        $fatal(1, "sirv_bootrom_icb: DP out of range");
    end
    if (TGT_ADDR[11:0] != 12'h000) begin : g_tgt_chk
        $fatal(1, "sirv_bootrom_icb: TGT_ADDR must be 4 KB aligned");
    end

    logic          sel_q;
    logic          sel_vld;
    logic [IW-1:0] idx;
    logic          oor;
    logic          accept;
    logic [31:0]   img_word;

    // Write payload and byte offset carry no information for a ROM.
    logic unused_ok;
    assign unused_ok = ^{icb_cmd_wdata, icb_cmd_wmask, icb_cmd_addr[1:0]};

    // Strap is captured once; sel_vld gates the command port until then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q   <= 1'b0;
            sel_vld <= 1'b0;
        end else if (!sel_vld) begin
            sel_q   <= boot_sel;
            sel_vld <= 1'b1;
        end
    end

    assign idx           = icb_cmd_addr[AW-1:2];
    assign oor           = 32'(idx) >= 32'(DP);
    assign icb_cmd_ready = sel_vld & (~icb_rsp_valid | icb_rsp_ready);
    assign accept        = icb_cmd_valid & icb_cmd_ready;

    sirv_bootrom_img #(
        .IW       (IW),
        .DP       (DP),
        .TGT_ADDR (TGT_ADDR),
        .CFG_WORD (CFG_WORD)
    ) u_img (
        .sel  (sel_q),
        .idx  (idx),
        .word (img_word)
    );

    // One-deep response buffer: a new accept overwrites it in the same cycle
    // the previous response is taken, so back-to-back reads see no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icb_rsp_valid <= 1'b0;
            icb_rsp_rdata <= '0;
            icb_rsp_err   <= 1'b0;
        end else if (accept) begin
            icb_rsp_valid <= 1'b1;
            icb_rsp_err   <= ~icb_cmd_read | oor;
            icb_rsp_rdata <= (icb_cmd_read && !oor) ? img_word : '0;
        end else if (icb_rsp_ready) begin
            icb_rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sirv_bootrom_icb.sv
// tb/tb_sirv_bootrom_icb.sv - directed self-checking bench for sirv_bootrom_icb
module tb_sirv_bootrom_icb;

    logic        clk;
    logic        rst_n;
    logic        boot_sel;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [11:0] cmd_addr;
    logic        cmd_read;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        c8_valid;
    logic        c8_ready;
    logic [11:0] c8_addr;
    logic        c8_read;
    logic        r8_valid;
    logic [31:0] r8_rdata;
    logic        r8_err;

    int n_chk;
    int n_fail;

    logic [31:0] xip_exp [6];

    sirv_bootrom_icb u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .boot_sel      (boot_sel),
        .icb_cmd_valid (cmd_valid),
        .icb_cmd_ready (cmd_ready),
        .icb_cmd_addr  (cmd_addr),
        .icb_cmd_read  (cmd_read),
        .icb_cmd_wdata (cmd_wdata),
        .icb_cmd_wmask (cmd_wmask),
        .icb_rsp_valid (rsp_valid),
        .icb_rsp_ready (rsp_ready),
        .icb_rsp_rdata (rsp_rdata),
        .icb_rsp_err   (rsp_err)
    );

    sirv_bootrom_icb #(.DP(8)) u_dut8 (
        .clk           (clk),
        .rst_n         (rst_n),
        .boot_sel      (boot_sel),
        .icb_cmd_valid (c8_valid),
        .icb_cmd_ready (c8_ready),
        .icb_cmd_addr  (c8_addr),
        .icb_cmd_read  (c8_read),
        .icb_cmd_wdata (32'h0),
        .icb_cmd_wmask (4'h0),
        .icb_rsp_valid (r8_valid),
        .icb_rsp_ready (1'b1),
        .icb_rsp_rdata (r8_rdata),
        .icb_rsp_err   (r8_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        xip_exp = '{32'h0100_006f, 32'h0000_0013, 32'h0000_0013,
                    32'h0000_6661, 32'h8000_02b7, 32'h0002_8067};
        clk = 0; rst_n = 0; boot_sel = 0;
        cmd_valid = 0; cmd_addr = '0; cmd_read = 1; cmd_wdata = '0; cmd_wmask = '0;
        rsp_ready = 1;
        c8_valid = 0; c8_addr = '0; c8_read = 1;

        // Reset state
        cyc(); cyc();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata",     rsp_rdata,      32'd0);
        chk("rst_err",       32'(rsp_err),   32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);

        // Release reset: one cycle of strap capture before cmd_ready rises
        rst_n = 1;
        #1;
        chk("rel_cmd_ready0", 32'(cmd_ready), 32'd0);
        cyc();
        chk("rel_cmd_ready1", 32'(cmd_ready), 32'd1);

        // Direct image, pipelined reads of words 0..2
        cmd_valid = 1; cmd_read = 1; cmd_addr = 12'h000;
        cyc();
        chk("d0_valid", 32'(rsp_valid), 32'd1);
        chk("d0_rdata", rsp_rdata, 32'h8000_02b7);
        chk("d0_err",   32'(rsp_err), 32'd0);
        cmd_addr = 12'h004;
        cyc();
        chk("d1_rdata", rsp_rdata, 32'h0002_8067);
        chk("d1_err",   32'(rsp_err), 32'd0);
        cmd_addr = 12'h008;
        cyc();
        chk("d2_rdata", rsp_rdata, 32'h0000_0000);
        chk("d2_err",   32'(rsp_err), 32'd0);
        cmd_valid = 0;
        cyc();
        chk("d_idle_valid", 32'(rsp_valid), 32'd0);

        // Write is rejected and leaves the ROM untouched
        cmd_valid = 1; cmd_read = 0; cmd_addr = 12'h004;
        cmd_wdata = 32'hDEAD_BEEF; cmd_wmask = 4'hF;
        cyc();
        chk("wr_valid", 32'(rsp_valid), 32'd1);
        chk("wr_err",   32'(rsp_err),   32'd1);
        chk("wr_rdata", rsp_rdata,      32'd0);
        cmd_read = 1; cmd_wdata = '0; cmd_wmask = '0;
        cyc();
        chk("rd_after_wr_rdata", rsp_rdata, 32'h0002_8067);
        chk("rd_after_wr_err",   32'(rsp_err), 32'd0);
        cmd_valid = 0;
        cyc();

        // Backpressure: response held while a pending command waits
        cmd_valid = 1; cmd_addr = 12'h000;
        cyc();
        chk("bp_first_rdata", rsp_rdata, 32'h8000_02b7);
        rsp_ready = 0; cmd_addr = 12'h008;
        #1;
        chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
            chk("bp_hold_rdata", rsp_rdata, 32'h8000_02b7);
            chk("bp_hold_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1; cmd_addr = 12'h004;
        #1;
        chk("bp_rel_ready", 32'(cmd_ready), 32'd1);
        cyc();
        chk("bp_next_valid", 32'(rsp_valid), 32'd1);
        chk("bp_next_rdata", rsp_rdata, 32'h0002_8067);
        cmd_valid = 0;
        cyc();
        chk("bp_drain_valid", 32'(rsp_valid), 32'd0);

        // Strap change after capture has no effect
        boot_sel = 1;
        cyc();
        cmd_valid = 1; cmd_addr = 12'h000; rsp_ready = 0;
        cyc();
        chk("strap_frozen_rdata", rsp_rdata, 32'h8000_02b7);
        chk("pend_valid", 32'(rsp_valid), 32'd1);

        // Reset with a pending response discards it immediately
        cmd_valid = 0;
        rst_n = 0;
        #1;
        chk("arst_valid", 32'(rsp_valid), 32'd0);
        chk("arst_rdata", rsp_rdata, 32'd0);
        rsp_ready = 1;
        cyc();
        rst_n = 1;
        #1;
        chk("rerel_cmd_ready0", 32'(cmd_ready), 32'd0);
        cyc();
        chk("rerel_cmd_ready1", 32'(cmd_ready), 32'd1);

        // XIP image, six back-to-back reads
        cmd_valid = 1; cmd_read = 1;
        for (int i = 0; i < 6; i++) begin
            cmd_addr = 12'(i * 4);
            cyc();
            chk($sformatf("xip%0d_valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("xip%0d_rdata", i), rsp_rdata, xip_exp[i]);
            chk($sformatf("xip%0d_err", i),   32'(rsp_err), 32'd0);
        end
        cmd_addr = 12'h018;
        cyc();
        chk("xip6_rdata", rsp_rdata, 32'd0);
        cmd_valid = 0;
        cyc();

        // DP=8 instance: range boundary
        chk("dp8_ready", 32'(c8_ready), 32'd1);
        c8_valid = 1; c8_read = 1; c8_addr = 12'h020;
        cyc();
        chk("dp8_oor_valid", 32'(r8_valid), 32'd1);
        chk("dp8_oor_err",   32'(r8_err),   32'd1);
        chk("dp8_oor_rdata", r8_rdata,      32'd0);
        c8_addr = 12'h01C;
        cyc();
        chk("dp8_last_err",   32'(r8_err), 32'd0);
        chk("dp8_last_rdata", r8_rdata,    32'd0);
        c8_addr = 12'h014;
        cyc();
        chk("dp8_w5_rdata", r8_rdata, 32'h0002_8067);
        c8_addr = 12'hFFC;
        cyc();
        chk("dp8_top_err", 32'(r8_err), 32'd1);
        c8_valid = 0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
